uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Parametrised successor to the fixed 8N1 9600-baud transmitter. Adds the following:
- Generic baud divisor, 5–8 data bits, optional parity and 1 or 2 stop bits.
- A small transmit FIFO, so the core can queue bytes without waiting for each frame.
- Back-to-back framing with no idle gap between frames.

Sits between the memory-mapped debug/console register and the UART TX pin.

Parameters:
CLOCK_HZ, 6000000, core clock frequency in Hz
BAUD, 9600, line rate; CYCLES_PER_BIT = CLOCK_HZ/BAUD (integer, truncated, must be >= 2)
DATA_BITS, 8, data bits per frame, legal 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2
FIFO_DEPTH, 4, FIFO entries, power of two, >= 2

Ports:
clock  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (asserted when 0)
tx_data  input  DATA_BITS  word to enqueue
tx_data_available  input  1  push request
tx_ready  output  1  FIFO not full; push occurs on an edge where tx_data_available && tx_ready
fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied entries
tx_busy  output  1  frame in progress (state != IDLE)
serial_tx  output  1  UART line, registered, idle high

Behaviour:
- Reset (reset==0 at an edge):
  - State becomes IDLE; FIFO is emptied, fifo_count=0; baud counter=0.
  - serial_tx=1; tx_busy=0; tx_ready=1.
  - Pushes presented while reset is asserted are dropped.
  - Reset mid-frame aborts the frame; line returns high on the next edge.
- tx_ready = (fifo_count < FIFO_DEPTH), combinational from registered count.
  - When full, a pop in the same cycle does NOT allow a push; the push waits one cycle.
- FIFO: circular read/write pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop leaves fifo_count unchanged.
- State machine: IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> IDLE or START.
- IDLE:
  - If fifo_count != 0: pop the head word, load the shift register, compute parity from the popped word, set serial_tx=0 and enter START, all on the same edge.
  - Latency: a word pushed into an empty FIFO while IDLE at edge N drives serial_tx low after edge N+1.
- Bit timing:
  - Every bit (start, data, parity, stop) holds serial_tx for exactly CYCLES_PER_BIT cycles.
  - The baud counter counts 0..CYCLES_PER_BIT-1 and clears on each bit transition and on frame start.
- DATA: sends DATA_BITS bits, LSB first.
- PARITY: one bit.
  - Odd: XOR of the data bits inverted.
  - Even: XOR of the data bits.
- STOP: line high for STOP_BITS bit periods.
  - At the end of the last stop period, if the FIFO is non-empty, pop and go directly to START on that edge (no idle cycle).
  - Otherwise go to IDLE.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CYCLES_PER_BIT cycles.
- tx_busy is 1 from the START-entry edge until the IDLE-entry edge.

Optional Feature:
UART_TX_CTS_EN:
- Defined:
  - Adds port cts_n, input, 1 bit, active-low clear-to-send, synchronised internally through 2 flops.
  - A new frame (IDLE->START or STOP->START) starts only when synchronised cts_n==0; otherwise stays in or enters IDLE.
  - A frame already in progress always completes, regardless of cts_n.
- Not defined: no cts_n port; frames start whenever the FIFO is non-empty.

Test Plan:
1. CLOCK_HZ=1600, BAUD=100 (16 cycles/bit), 8N1. Push 0x55 into an idle block → serial_tx low one edge after the push, then 1,0,1,0,1,0,1,0, then stop 1. Each level lasts 16 cycles; total 160 cycles; tx_busy high throughout.
2. Same divisor, PARITY=2 then PARITY=1. Send 0xA3 → parity bit 0 (even), 1 (odd). Frame is 176 cycles.
3. DATA_BITS=7, STOP_BITS=2. Send 0x7F → start 0, seven 1s, two stop periods. Frame is 160 cycles; bit 7 of the input is ignored.
4. FIFO_DEPTH=4. Push 6 words on consecutive cycles, holding tx_data_available →
   - Words 0–4 are accepted (word 0 is popped at once).
   - tx_ready goes low with fifo_count=4; word 5 is accepted only after word 0's frame ends.
   - All 6 frames are back-to-back with no idle cycle between stop and start.
5. Assert reset (0) midway through a data bit → serial_tx=1, fifo_count=0, tx_busy=0 after that edge. A push afterwards starts a clean frame.
6. With UART_TX_CTS_EN:
   - Hold cts_n=1 and push 0x41 → line stays high and fifo_count=1.
   - Drop cts_n to 0 → start bit begins 3 edges later.
   - Raise cts_n mid-frame → the frame completes.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO, configurable framing (5..8 data bits,
// none/odd/even parity, 1 or 2 stop bits) and gapless back-to-back frames.
// Define UART_TX_CTS_EN to add the active-low clear-to-send input cts_n.
module uart_tx_fifo #(
  parameter int CLOCK_HZ   = 6000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
`ifdef UART_TX_CTS_EN
  input  logic                          cts_n,
`endif
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_data_available,
  output logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_busy,
  output logic                          serial_tx
);

  localparam int CYCLES_PER_BIT = CLOCK_HZ / BAUD;
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT);
  localparam int PTR_W          = $clog2(FIFO_DEPTH);
  localparam bit PARITY_ODD     = (PARITY == 1);
  localparam bit PARITY_EN      = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 ser_q, ser_d;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0]       count_q, count_d;

  logic                 push, pop, last_cycle, cts_ok, can_start;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

`ifdef UART_TX_CTS_EN
  logic cts_meta_q, cts_sync_q;

  // Two-flop synchroniser; reset to "not clear" so nothing starts until CTS is seen.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      cts_meta_q <= cts_n;
      cts_sync_q <= cts_meta_q;
    end
  end

  assign cts_ok = ~cts_sync_q;
`else
  assign cts_ok = 1'b1;
`endif

  // Full blocks pushes even if a pop happens on the same edge.
  assign tx_ready   = (count_q < (PTR_W+1)'(FIFO_DEPTH));
  assign push       = tx_data_available && tx_ready;
  assign head       = mem_q[rd_q];
  assign head_par   = (^head) ^ PARITY_ODD;
  assign can_start  = (count_q != '0) && cts_ok;
  assign last_cycle = (baud_cnt_q == CNT_W'(CYCLES_PER_BIT - 1));

  assign fifo_count = count_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign serial_tx  = ser_q;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    count_d = count_q;
    if (push) begin
      mem_d[wr_q] = tx_data;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_d = rd_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + CNT_W'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    ser_d      = ser_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_cnt_d = '0;
        ser_d      = 1'b1;
        if (can_start) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = head_par;
          ser_d   = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (last_cycle) begin
          baud_cnt_d = '0;
          ser_d      = shift_q[0];
          shift_d    = shift_q >> 1;
          bit_d      = '0;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (last_cycle) begin
          baud_cnt_d = '0;
          if (bit_q == 3'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (PARITY_EN) begin
              ser_d   = par_q;
              state_d = S_PARITY;
            end else begin
              ser_d   = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            ser_d   = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (last_cycle) begin
          baud_cnt_d = '0;
          bit_d      = '0;
          ser_d      = 1'b1;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (last_cycle) begin
          baud_cnt_d = '0;
          if (bit_q == 3'(STOP_BITS - 1)) begin
            // Chain straight into the next start bit when a word is waiting.
            if (can_start) begin
              pop     = 1'b1;
              shift_d = head;
              par_d   = head_par;
              ser_d   = 1'b0;
              state_d = S_START;
            end else begin
              ser_d   = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        ser_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      ser_q      <= 1'b1;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      ser_q      <= ser_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
    end
  end

endmodule
